// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART byte transmitter between NUM_REQ sources.
// Grant 1 cycle after request; each byte is a 1-cycle tx_start/req_ready pulse; the lock holds until last or timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 tx_err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic [LOCK_W-1:0] lock_cnt;
  logic [BUSY_W-1:0] busy_cnt;
  logic              last_f;

  logic              owner_valid;
  logic              owner_last;
  logic [7:0]        owner_data;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scan downward so the requester closest after rr_ptr overrides the rest.
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[wrap_idx(rr_ptr, i)]) winner = wrap_idx(rr_ptr, i);
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      tx_err    <= 1'b0;
      rr_ptr    <= LAST_IDX;
      owner     <= '0;
      lock_cnt  <= '0;
      busy_cnt  <= '0;
      last_f    <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && (|req_valid)) begin
            grant    <= onehot(winner);
            owner    <= winner;
            lock_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (owner_valid) begin
            if (!tx_busy) begin
              tx_start  <= 1'b1;
              req_ready <= onehot(owner);
              tx_data   <= owner_data;
              last_f    <= owner_last;
              lock_cnt  <= '0;
              busy_cnt  <= '0;
              state     <= WAIT_BUSY;
            end
          end else if (lock_cnt == LOCK_LAST) begin
            // Owner went quiet mid-packet: give everyone else a turn.
            grant  <= '0;
            rr_ptr <= owner;
            state  <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == BUSY_LAST) begin
            // Transmitter never acknowledged; flag it and move on as if the frame ended.
            tx_err <= 1'b1;
            if (last_f) begin
              grant  <= '0;
              rr_ptr <= owner;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_f) begin
              grant  <= '0;
              rr_ptr <= owner;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle transmitter busy model (can be muted).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_err;

  int   checks;
  int   errors;
  bit   mute;
  int   busy_left;
  logic [3:0] ready_acc;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .LOCK_TIMEOUT(8),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_err(tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter: busy for 10 cycles after each start unless muted.
  initial begin
    tx_busy   = 1'b0;
    busy_left = 0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !mute) begin
        busy_left = 10;
        tx_busy   = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      ready_acc = ready_acc | req_ready;
      if (tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (grant === 4'b0000 && tx_busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 4'b1111;
    req_data  = 32'h1234_5678;
    req_last  = 4'b1111;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0061;
    req_last  = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_no_early_start: got %b want 0", tx_start); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    checks++; if (tx_data !== 8'h61) begin errors++; $display("FAIL single_data: got %h want 61", tx_data); end
    req_valid = 4'b0000;
    req_data  = 32'h0000_00FF;
    repeat (10) @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_hold_grant: got %b want 0001", grant); end
    checks++; if (tx_data !== 8'h61) begin errors++; $display("FAIL single_data_stable: got %h want 61", tx_data); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b want 0000", grant); end
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: got busy want idle"); end
  endtask

  task automatic test_round_robin;
    bit seen;
    bit ok;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req_data  = 32'h1312_1110;
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'h10 + 8'(k % 4);
      wait_start(60, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rr_start_%0d: got no tx_start want tx_start", k);
      end else if (tx_data !== exp_d || grant !== exp_g || req_ready !== exp_g) begin
        errors++;
        $display("FAIL rr_byte_%0d: got data %h grant %b ready %b want data %h grant %b ready %b",
                 k, tx_data, grant, req_ready, exp_d, exp_g, exp_g);
      end
    end
    req_valid = 4'b0000;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle: got busy want idle"); end
  endtask

  task automatic test_packet_lock;
    bit seen;
    bit ok;
    logic [7:0] exp_d;
    do_reset();
    req_data  = 32'h0000_B0A0;
    req_last  = 4'b0010;
    req_valid = 4'b0011;
    ready_acc = '0;
    for (int k = 0; k < 3; k++) begin
      exp_d = 8'hA0 + 8'(k);
      wait_start(60, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL lock_start_%0d: got no tx_start want tx_start", k);
      end else if (tx_data !== exp_d || grant !== 4'b0001 || req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL lock_byte_%0d: got data %h grant %b ready %b want data %h grant 0001 ready 0001",
                 k, tx_data, grant, req_ready, exp_d);
      end
      if (k < 2) begin
        req_data[7:0] = 8'hA1 + 8'(k);
        req_last[0]   = (k == 1);
      end else begin
        req_valid[0] = 1'b0;
      end
    end
    checks++; if (ready_acc[1] !== 1'b0) begin errors++; $display("FAIL lock_no_ready1: got %b want 0", ready_acc[1]); end
    wait_start(60, seen);
    checks++;
    if (!seen || grant !== 4'b0010 || tx_data !== 8'hB0) begin
      errors++; $display("FAIL lock_next_owner: got seen %0d grant %b data %h want seen 1 grant 0010 data b0", seen, grant, tx_data);
    end
    req_valid = 4'b0000;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_idle: got busy want idle"); end
  endtask

  task automatic test_lock_timeout;
    bit seen;
    bit ok;
    do_reset();
    req_data  = 32'h0077_0055;
    req_last  = 4'b0100;
    req_valid = 4'b0101;
    wait_start(60, seen);
    checks++;
    if (!seen || grant !== 4'b0001 || tx_data !== 8'h55) begin
      errors++; $display("FAIL to_first_byte: got seen %0d grant %b data %h want seen 1 grant 0001 data 55", seen, grant, tx_data);
    end
    req_valid[0] = 1'b0;
    // 11 cycles to re-enter SEND, then 8 cycles of lock timeout.
    repeat (18) @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_still_locked: got %b want 0001", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_release: got %b want 0000", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_regrant: got %b want 0100", grant); end
    wait_start(60, seen);
    checks++;
    if (!seen || tx_data !== 8'h77 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL to_req2_byte: got seen %0d data %h ready %b want seen 1 data 77 ready 0100", seen, tx_data, req_ready);
    end
    req_valid = 4'b0000;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_idle: got busy want idle"); end
  endtask

  task automatic test_busy_timeout;
    bit seen;
    bit ok;
    do_reset();
    mute      = 1'b1;
    req_data  = 32'h0000_0031;
    req_last  = 4'b0000;
    req_valid = 4'b0001;
    wait_start(60, seen);
    checks++;
    if (!seen || tx_data !== 8'h31) begin
      errors++; $display("FAIL bt_first_byte: got seen %0d data %h want seen 1 data 31", seen, tx_data);
    end
    req_data[7:0] = 8'h32;
    req_last[0]   = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL bt_no_early_err: got %b want 0", tx_err); end
    @(negedge clk);
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL bt_err_pulse: got %b want 1", tx_err); end
    @(negedge clk);
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL bt_err_one_cycle: got %b want 0", tx_err); end
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h32) begin
      errors++; $display("FAIL bt_next_byte: got start %b data %h want start 1 data 32", tx_start, tx_data);
    end
    req_valid = 4'b0000;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bt_idle: got busy want idle"); end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    bit seen;
    bit ok;
    do_reset();
    req_data  = 32'h0000_4241;
    req_last  = 4'b0011;
    req_valid = 4'b0010;
    wait_start(60, seen);
    checks++;
    if (!seen || grant !== 4'b0010 || tx_data !== 8'h42) begin
      errors++; $display("FAIL rm_first_byte: got seen %0d grant %b data %h want seen 1 grant 0010 data 42", seen, grant, tx_data);
    end
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (grant !== 4'b0000 || tx_start !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rm_after_reset: got grant %b start %b ready %b want 0000 0 0000", grant, tx_start, req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_blocked_%0d: got %b want 0000", i, grant); end
    end
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_regrant: got %b want 0001", grant); end
    wait_start(60, seen);
    checks++;
    if (!seen || tx_data !== 8'h41) begin
      errors++; $display("FAIL rm_req0_byte: got seen %0d data %h want seen 1 data 41", seen, tx_data);
    end
    req_valid = 4'b0000;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_idle: got busy want idle"); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mute      = 1'b0;
    ready_acc = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_lock_timeout();
    test_busy_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
